// File: rtl/l2_cache_control.sv
// l2_cache_control: L2 cache control FSM sequencing hits, dirty writeback and line allocation.
module l2_cache_control #(
  parameter int TAG_W = 7,
  parameter int IDX_W = 4,
  parameter int OFF_W = 5,
  parameter int CNT_W = 16,
  localparam int AW = TAG_W + IDX_W + OFF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [AW-1:0]    mem_address,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [AW-1:0]    pmem_address,
  input  logic             hit,
  input  logic [1:0]       curr_way,
  input  logic [1:0]       lru_out,
  input  logic             dirty0_out,
  input  logic             dirty1_out,
  input  logic             dirty2_out,
  input  logic             dirty3_out,
  input  logic [TAG_W-1:0] pmem_tag,
  output logic             ld_cache,
  output logic             ld_dirty0,
  output logic             ld_dirty1,
  output logic             ld_dirty2,
  output logic             ld_dirty3,
  output logic             dirty_clean,
  output logic             ld_lru,
  output logic             writecachemux_sel,
  output logic             data0mux_sel,
  output logic             data1mux_sel,
  output logic             data2mux_sel,
  output logic             data3mux_sel,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_t;
  state_t state, state_n;
  logic [3:0] dirty_v, ld_dirty_v, data_sel_v, cur_oh, lru_oh;
  logic req, hit_inc, miss_inc, unused_off;
  assign req = mem_read | mem_write;
  assign dirty_v = {dirty3_out, dirty2_out, dirty1_out, dirty0_out};
  assign cur_oh = 4'b0001 << curr_way;
  assign lru_oh = 4'b0001 << lru_out;
  assign {ld_dirty3, ld_dirty2, ld_dirty1, ld_dirty0} = ld_dirty_v;
  assign {data3mux_sel, data2mux_sel, data1mux_sel, data0mux_sel} = data_sel_v;
  assign unused_off = ^mem_address[OFF_W-1:0];
  always_comb begin
    state_n = state;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    ld_cache = 1'b0;
    ld_dirty_v = '0;
    dirty_clean = 1'b0;
    ld_lru = 1'b0;
    writecachemux_sel = 1'b0;
    data_sel_v = '0;
    hit_inc = 1'b0;
    miss_inc = 1'b0;
    unique case (state)
      IDLE: state_n = req ? CHECK : IDLE;
      CHECK: begin
        if (!req) state_n = IDLE;
        else if (hit) begin
          mem_resp = 1'b1;
          ld_lru = 1'b1;
          hit_inc = 1'b1;
          state_n = IDLE;
          // write wins when both request lines are high
          if (mem_write) begin
            writecachemux_sel = 1'b1;
            data_sel_v = cur_oh;
            ld_dirty_v = cur_oh;
            dirty_clean = 1'b1;
          end
        end else begin
          miss_inc = 1'b1;
          state_n = dirty_v[lru_out] ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_address = {pmem_tag, mem_address[OFF_W+IDX_W-1:OFF_W], {OFF_W{1'b0}}};
        if (pmem_resp) begin
          ld_dirty_v = lru_oh;
          state_n = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        pmem_address = {mem_address[AW-1:OFF_W], {OFF_W{1'b0}}};
        if (pmem_resp) begin
          ld_cache = 1'b1;
          ld_dirty_v = lru_oh;
          state_n = CHECK;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      state <= state_n;
      if (hit_inc && !(&hit_count)) hit_count <= hit_count + CNT_W'(1);
      if (miss_inc && !(&miss_count)) miss_count <= miss_count + CNT_W'(1);
    end
endmodule
